// File: rtl/core_pkg.sv
// Shared RV32 core definitions: base opcodes and the pipeline sequencer state type.
package core_pkg;

  localparam logic [6:0] LUI   = 7'b0110111;
  localparam logic [6:0] AUIPC = 7'b0010111;
  localparam logic [6:0] JAL   = 7'b1101111;
  localparam logic [6:0] JALR  = 7'b1100111;
  localparam logic [6:0] BCC   = 7'b1100011;
  localparam logic [6:0] LCC   = 7'b0000011;
  localparam logic [6:0] SCC   = 7'b0100011;
  localparam logic [6:0] MCC   = 7'b0010011;
  localparam logic [6:0] RCC   = 7'b0110011;
  localparam logic [6:0] SYS   = 7'b1110011;
  localparam logic [6:0] CUS   = 7'b0001011;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MEMWAIT = 2'd1,
    FLUSH   = 2'd2,
    LDSTALL = 2'd3
  } pipe_state_t;

  // rs1 is a real source operand unless the format has no rs1 field
  function automatic logic reads_rs1(input logic [6:0] op);
    return !(op == LUI || op == AUIPC || op == JAL);
  endfunction

  // rs2 is a real source operand only for B, S and R formats
  function automatic logic reads_rs2(input logic [6:0] op);
    return (op == BCC || op == SCC || op == RCC);
  endfunction

endpackage

// File: rtl/pipe_hazard_detect.sv
// Combinational load-use hazard comparator between the EX load and the ID consumer.
module pipe_hazard_detect
  import core_pkg::*;
(
  input  logic [31:0] if_id_inst,
  input  logic [31:0] id_ex_inst,
  input  logic [4:0]  id_ex_rd,
  output logic        ldu
);

  logic ex_is_load;
  logic rs1_hit;
  logic rs2_hit;

  // flag a dependency of the decode instruction on a load result not yet available
  always_comb begin
    ex_is_load = (id_ex_inst[6:0] == LCC) && (id_ex_inst != '0) && (id_ex_rd != '0);
    rs1_hit    = (id_ex_rd == if_id_inst[19:15]) && reads_rs1(if_id_inst[6:0]);
    rs2_hit    = (id_ex_rd == if_id_inst[24:20]) && reads_rs2(if_id_inst[6:0]);
    ldu        = ex_is_load && (rs1_hit || rs2_hit);
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard / flush sequencer: load-use stalls, data-memory waits and
// branch/jump flush windows. Optional performance counters: PIPE_CTRL_PERF_EN.
module pipe_ctrl
  import core_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        RESN,
  input  logic [31:0] IF_ID_inst,
  input  logic [31:0] ID_EX_inst,
  input  logic [4:0]  ID_EX_rd,
  input  logic        branch_req,
  input  logic        jump_req,
  input  logic        dmem_req,
  input  logic        dmem_ack,
  output logic        HLT,
  output logic        IF_flush,
  output logic        ID_bubble,
  output logic [1:0]  state_o,
  output logic [31:0] perf_stall,
  output logic [31:0] perf_flush,
  output logic [31:0] perf_ldu
);

  pipe_state_t state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        pend_jump_q, pend_jump_d;
  logic        pend_branch_q, pend_branch_d;

  logic ldu;
  logic mem_stall;
  logic jump_eff;
  logic branch_eff;
  logic hlt_c;
  logic flush_c;
  logic bubble_c;
  logic ldu_enter;

  pipe_hazard_detect u_hazard (
    .if_id_inst (IF_ID_inst),
    .id_ex_inst (ID_EX_inst),
    .id_ex_rd   (ID_EX_rd),
    .ldu        (ldu)
  );

  // next-state and Mealy control outputs; pending flushes from a memory wait
  // are merged into RUN's request inputs so they obey RUN's priority order
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    pend_jump_d   = pend_jump_q;
    pend_branch_d = pend_branch_q;
    hlt_c         = 1'b0;
    flush_c       = 1'b0;
    bubble_c      = 1'b0;
    ldu_enter     = 1'b0;
    mem_stall     = dmem_req && !dmem_ack;
    jump_eff      = jump_req || pend_jump_q;
    branch_eff    = branch_req || pend_branch_q;
    unique case (state_q)
      RUN: begin
        if (mem_stall) begin
          hlt_c   = 1'b1;
          state_d = MEMWAIT;
        end else if (jump_eff) begin
          flush_c       = 1'b1;
          bubble_c      = 1'b1;
          pend_jump_d   = 1'b0;
          pend_branch_d = 1'b0;
        end else if (branch_eff) begin
          flush_c       = 1'b1;
          pend_jump_d   = 1'b0;
          pend_branch_d = 1'b0;
          if (FLUSH_CYCLES > 1) begin
            cnt_d   = 3'(FLUSH_CYCLES - 1);
            state_d = FLUSH;
          end
        end else if (ldu) begin
          hlt_c     = 1'b1;
          bubble_c  = 1'b1;
          ldu_enter = 1'b1;
          state_d   = LDSTALL;
        end
      end
      MEMWAIT: begin
        hlt_c         = !dmem_ack;
        pend_jump_d   = pend_jump_q || jump_req;
        pend_branch_d = pend_branch_q || branch_req;
        if (dmem_ack) state_d = RUN;
      end
      FLUSH: begin
        if (mem_stall) begin
          hlt_c   = 1'b1;
          cnt_d   = '0;
          state_d = MEMWAIT;
        end else begin
          flush_c  = 1'b1;
          bubble_c = jump_req;
          cnt_d    = cnt_q - 3'd1;
          if (cnt_q <= 3'd1) state_d = RUN;
        end
      end
      LDSTALL: begin
        state_d = RUN;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // sequencer registers
  always_ff @(posedge CLK or negedge RESN) begin
    if (!RESN) begin
      state_q       <= RUN;
      cnt_q         <= '0;
      pend_jump_q   <= 1'b0;
      pend_branch_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      pend_jump_q   <= pend_jump_d;
      pend_branch_q <= pend_branch_d;
    end
  end

  // controls are forced low while reset is held, even mid-window
  always_comb begin
    HLT       = RESN && hlt_c;
    IF_flush  = RESN && flush_c;
    ID_bubble = RESN && bubble_c;
    state_o   = RESN ? state_q : RUN;
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_flush_q, perf_flush_d;
  logic [31:0] perf_ldu_q, perf_ldu_d;

  // saturating event counters
  always_comb begin
    perf_stall_d = perf_stall_q;
    perf_flush_d = perf_flush_q;
    perf_ldu_d   = perf_ldu_q;
    if (HLT && perf_stall_q != '1)      perf_stall_d = perf_stall_q + 32'd1;
    if (IF_flush && perf_flush_q != '1) perf_flush_d = perf_flush_q + 32'd1;
    if (ldu_enter && perf_ldu_q != '1)  perf_ldu_d   = perf_ldu_q + 32'd1;
  end

  // counter registers
  always_ff @(posedge CLK or negedge RESN) begin
    if (!RESN) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
      perf_ldu_q   <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_flush_q <= perf_flush_d;
      perf_ldu_q   <= perf_ldu_d;
    end
  end

  assign perf_stall = perf_stall_q;
  assign perf_flush = perf_flush_q;
  assign perf_ldu   = perf_ldu_q;
`else
  logic unused_ldu_enter;
  assign unused_ldu_enter = ldu_enter;
  assign perf_stall = '0;
  assign perf_flush = '0;
  assign perf_ldu   = '0;
`endif

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline hazard and flush sequencer for the five-stage RV32 core. It sits beside the decode stage and owns three front-end controls: the pipeline freeze `HLT`, the fetch flush, and the ID/EX bubble. It sequences load-use stalls, data-memory wait states and branch/jump flush windows. It replaces the ad-hoc flush suppression buffers with one explicit state machine.

## Interface
- `FLUSH_CYCLES`, default 2: number of cycles `IF_flush` stays asserted after a taken decode-stage branch. Legal range is 1..7.
- `CLK` in 1: rising-edge clock.
- `RESN` in 1: reset, asynchronous, active-low.
- `IF_ID_inst` in 32: instruction currently in decode.
- `ID_EX_inst` in 32: instruction in execute. 0 means bubble.
- `ID_EX_rd` in 5: destination register of `ID_EX_inst`.
- `branch_req` in 1: decode resolved a taken conditional branch this cycle.
- `jump_req` in 1: execute is redirecting the PC for JAL/JALR this cycle.
- `dmem_req` in 1: MEM stage has a valid load/store outstanding.
- `dmem_ack` in 1: data memory completes the access this cycle.
- `HLT` out 1: freeze PC, IF/ID and ID/EX.
- `IF_flush` out 1: load a zero instruction into IF/ID.
- `ID_bubble` out 1: load a zero instruction into ID/EX.
- `state_o` out 2: current state, for debug.
- `perf_stall`, `perf_flush`, `perf_ldu` out 32 each: performance counters (see Configuration).

## Operation
- States: RUN=0, MEMWAIT=1, FLUSH=2, LDSTALL=3.
- Load-use hazard (`ldu`) is true when all of the following hold:
  - `ID_EX_inst[6:0]`=0000011, `ID_EX_inst`≠0 and `ID_EX_rd`≠0;
  - and either `ID_EX_rd`==`IF_ID_inst[19:15]` with the IF/ID opcode not LUI, AUIPC or JAL;
  - or `ID_EX_rd`==`IF_ID_inst[24:20]` with the IF/ID opcode BCC, SCC or RCC.
- Priority, highest first: memory wait, `jump_req`, `branch_req`, `ldu`.
- RUN:
  - If `dmem_req && !dmem_ack`: `HLT`=1 and go to MEMWAIT.
  - Else if `jump_req`: `IF_flush`=1 and `ID_bubble`=1, stay in RUN.
  - Else if `branch_req`: `IF_flush`=1, load counter with `FLUSH_CYCLES`-1, go to FLUSH. If `FLUSH_CYCLES`=1, stay in RUN instead.
  - Else if `ldu`: `ID_bubble`=1 with `HLT` held for IF/ID only, meaning the PC and IF/ID freeze while ID/EX takes the bubble. Go to LDSTALL.
- MEMWAIT:
  - `HLT`=1 while `!dmem_ack`.
  - In the `dmem_ack` cycle, `HLT`=0 and go to RUN.
  - `jump_req` or `branch_req` seen here sets a pending flag. The pending flush is issued in the first RUN cycle with RUN's priority rules.
- FLUSH:
  - `IF_flush`=1 each cycle; counter decrements and the state returns to RUN when it reaches 0.
  - `branch_req` is ignored here.
  - `jump_req` additionally asserts `ID_bubble` but does not extend the window.
  - A memory stall here takes priority: go to MEMWAIT, and the remaining flush count is dropped.
- LDSTALL: lasts exactly one cycle and all outputs are 0. `ldu` cannot re-fire because ID/EX now holds a bubble. Go to RUN.
- `HLT` semantics: when both `HLT` and `ID_bubble` are 1, ID/EX loads the bubble and all other pipeline registers hold.

## Timing
- Outputs are combinational (Mealy) from the registered state, the counter and the current inputs. The state, counter and pending flag update on `CLK` rising edge.
- Detection-to-control latency is 0 cycles. Stall cost per event:
  - load-use: 1 cycle;
  - taken branch: `FLUSH_CYCLES` cycles;
  - jump: 1 cycle;
  - memory: cycles to `dmem_ack`.
- `dmem_req` and `dmem_ack` in the same RUN cycle: no stall.
- Reset:
  - `RESN` low asynchronously forces RUN, counter 0 and pending 0.
  - All outputs are gated to 0 while `RESN`=0, including when reset is asserted mid-FLUSH or mid-MEMWAIT.
  - First evaluation occurs on the first edge after release.

## Configuration
- `PIPE_CTRL_PERF_EN` defined: three saturating 32-bit counters, cleared by reset.
  - `perf_stall` counts cycles with `HLT`=1.
  - `perf_flush` counts cycles with `IF_flush`=1.
  - `perf_ldu` counts entries into LDSTALL.
- Not defined: the counters are not built and the ports are tied to 0.

## Structure
- Shared package `core_pkg`:
  - opcode constants LUI, AUIPC, JAL, JALR, BCC, LCC, SCC, MCC, RCC, SYS, CUS;
  - the `pipe_state_t` 2-bit enum.
- Sub-module `pipe_hazard_detect`: purely combinational `ldu` comparator, reusable by a future forwarding unit.

## Test plan
- Load `x5` then `add x6,x5,x1` (ID_EX_rd=5, rs1=5) -> one cycle `ID_bubble`=1 with IF/ID held, `state_o` 0→3→0, `perf_ldu`=1.
- `branch_req` pulse with `FLUSH_CYCLES`=2 -> `IF_flush`=1 for exactly 2 cycles. A second `branch_req` inside the window is ignored.
- `dmem_req`=1 with `dmem_ack` arriving after 3 cycles -> `HLT`=1 for 3 cycles and 0 in the ack cycle. A `jump_req` pulsed during the wait yields `IF_flush`=`ID_bubble`=1 in the first RUN cycle.
- Simultaneous `jump_req`, `branch_req` and `ldu` in RUN -> only `IF_flush`=`ID_bubble`=1, state stays RUN.
- `RESN` dropped mid-FLUSH and mid-MEMWAIT -> outputs 0 immediately. After release, `state_o`=0 and counters read 0.
- Load with `rd`=x0 followed by a use of x0 -> no stall.
